// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
package mem_access_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Word accesses only: the low two address bits must be zero.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port; the remote end may sit across the NoC.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_timeout_ctr.sv
// Loadable up-counter that flags when it reaches LIMIT-1.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load takes priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores over a variable-latency req/ack port,
// stalls upstream while an access is outstanding, and registers the M/W bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegW_enable_M,
  input  logic                  Mem_Write_M,
  input  logic                  Mem_Read_M,
  input  logic                  Result_src_M,
  input  logic [XLEN-1:0]       ALU_result_M,
  input  logic [XLEN-1:0]       Write_Data_M,
  input  logic [REG_ADDR_W-1:0] RDadd_M,
  mem_access_stage_if.master    dmem,
  output logic                  stall_M,
  output logic                  RegW_enable_W,
  output logic                  Result_src_W,
  output logic [XLEN-1:0]       ALU_result_W,
  output logic [XLEN-1:0]       Read_Data_W,
  output logic [REG_ADDR_W-1:0] RDadd_W,
  output logic                  mem_err,
  output logic                  mem_misalign
);

  mem_state_e            r_state;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [XLEN-1:0]       r_dmem_addr;
  logic [XLEN-1:0]       r_dmem_wdata;
  logic [XLEN-1:0]       r_rdata_cap;
  logic                  r_abort;
  logic                  r_mem_err;
  logic                  r_mem_misalign;
  logic                  r_regw_w;
  logic                  r_rsrc_w;
  logic [XLEN-1:0]       r_alu_w;
  logic [XLEN-1:0]       r_rdata_w;
  logic [REG_ADDR_W-1:0] r_rd_w;

  logic w_access;
  logic w_aligned;
  logic w_start;
  logic w_expired;
  logic w_cnt_en;

  assign w_access  = Mem_Read_M | Mem_Write_M;
  assign w_aligned = is_word_aligned(ALU_result_M);
  assign w_start   = (r_state == IDLE) && w_access && w_aligned;
  assign w_cnt_en  = (r_state == WAIT) && !dmem.dmem_ack;

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (CNT_W)
  ) u_timeout_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .o_expired  (w_expired)
  );

  // Stall is combinational so the upstream freezes in the same cycle the access is seen.
  assign stall_M = w_start || (r_state == WAIT);

  // Access FSM plus M/W register; stalled cycles push a bubble and hold the other W fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_wdata   <= '0;
      r_rdata_cap    <= '0;
      r_abort        <= 1'b0;
      r_mem_err      <= 1'b0;
      r_mem_misalign <= 1'b0;
      r_regw_w       <= 1'b0;
      r_rsrc_w       <= 1'b0;
      r_alu_w        <= '0;
      r_rdata_w      <= '0;
      r_rd_w         <= '0;
    end else begin
      r_mem_err      <= 1'b0;
      r_mem_misalign <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_access && !w_aligned) begin
            r_mem_misalign <= 1'b1;
            r_regw_w       <= 1'b0;
          end else if (w_access) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= Mem_Write_M;
            r_dmem_addr  <= {ALU_result_M[XLEN-1:2], 2'b00};
            r_dmem_wdata <= Write_Data_M;
            r_abort      <= 1'b0;
            r_regw_w     <= 1'b0;
            r_state      <= WAIT;
          end else begin
            r_regw_w  <= RegW_enable_M;
            r_rsrc_w  <= Result_src_M;
            r_alu_w   <= ALU_result_M;
            r_rdata_w <= '0;
            r_rd_w    <= RDadd_M;
          end
        end
        WAIT: begin
          r_regw_w <= 1'b0;
          // Ack is checked first so an ack on the expiry cycle still completes normally.
          if (dmem.dmem_ack) begin
            r_rdata_cap <= dmem.dmem_rdata;
            r_dmem_req  <= 1'b0;
            r_state     <= DONE;
          end else if (w_expired) begin
            r_rdata_cap <= '0;
            r_abort     <= 1'b1;
            r_dmem_req  <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_regw_w  <= RegW_enable_M && !r_abort;
          r_rsrc_w  <= Result_src_M;
          r_alu_w   <= ALU_result_M;
          r_rdata_w <= r_rdata_cap;
          r_rd_w    <= RDadd_M;
          r_mem_err <= r_abort;
          r_state   <= IDLE;
        end
        default: begin
          r_dmem_req <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = r_dmem_req;
  assign dmem.dmem_we    = r_dmem_we;
  assign dmem.dmem_addr  = r_dmem_addr;
  assign dmem.dmem_wdata = r_dmem_wdata;

  assign RegW_enable_W = r_regw_w;
  assign Result_src_W  = r_rsrc_w;
  assign ALU_result_W  = r_alu_w;
  assign Read_Data_W   = r_rdata_w;
  assign RDadd_W       = r_rd_w;
  assign mem_err       = r_mem_err;
  assign mem_misalign  = r_mem_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a transaction-level reference.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M;
  logic [31:0] ALU_result_M, Write_Data_M;
  logic [4:0]  RDadd_M;
  logic        stall_M, RegW_enable_W, Result_src_W, mem_err, mem_misalign;
  logic [31:0] ALU_result_W, Read_Data_W;
  logic [4:0]  RDadd_W;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RegW_enable_M (RegW_enable_M),
    .Mem_Write_M   (Mem_Write_M),
    .Mem_Read_M    (Mem_Read_M),
    .Result_src_M  (Result_src_M),
    .ALU_result_M  (ALU_result_M),
    .Write_Data_M  (Write_Data_M),
    .RDadd_M       (RDadd_M),
    .dmem          (bus),
    .stall_M       (stall_M),
    .RegW_enable_W (RegW_enable_W),
    .Result_src_W  (Result_src_W),
    .ALU_result_W  (ALU_result_W),
    .Read_Data_W   (Read_Data_W),
    .RDadd_W       (RDadd_W),
    .mem_err       (mem_err),
    .mem_misalign  (mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic regw, rd, wr, rsrc, input logic [31:0] alu, wd,
                       input logic [4:0] rdad);
    RegW_enable_M = regw; Mem_Read_M = rd; Mem_Write_M = wr; Result_src_M = rsrc;
    ALU_result_M = alu; Write_Data_M = wd; RDadd_M = rdad;
  endtask

  // Non-memory op: one cycle, bundle passes straight through; a stray ack is ignored.
  task automatic do_alu(input logic regw, rsrc, input logic [31:0] alu, input logic [4:0] rdad);
    drive(regw, 1'b0, 1'b0, rsrc, alu, $urandom(), rdad);
    bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom();
    #1;
    chk("alu_stall", stall_M, 0);
    chk("alu_req", bus.dmem_req, 0);
    step();
    bus.dmem_ack = 1'b0;
    chk("alu_regw", RegW_enable_W, regw);
    chk("alu_rsrc", Result_src_W, rsrc);
    chk("alu_res", ALU_result_W, alu);
    chk("alu_rdata", Read_Data_W, 0);
    chk("alu_rd", RDadd_W, rdad);
    chk("alu_err", mem_err, 0);
    chk("alu_mis", mem_misalign, 0);
  endtask

  // Misaligned access: no request, no stall, bubble plus a misalign pulse.
  task automatic do_misalign(input logic rd, wr, input logic [31:0] alu);
    drive(1'b1, rd, wr, 1'b1, alu, $urandom(), 5'($urandom()));
    #1;
    chk("mis_stall", stall_M, 0);
    chk("mis_req0", bus.dmem_req, 0);
    step();
    chk("mis_req1", bus.dmem_req, 0);
    chk("mis_regw", RegW_enable_W, 0);
    chk("mis_flag", mem_misalign, 1);
    chk("mis_err", mem_err, 0);
  endtask

  // Aligned access: memory answers after `lat` extra WAIT cycles; lat >= TO means it never answers.
  task automatic do_mem(input logic rd, wr, regw, rsrc, input logic [31:0] addr, wd,
                        input logic [4:0] rdad, input int unsigned lat, input logic [31:0] rdata);
    int unsigned nwait;
    int unsigned nstall;
    logic        tout;
    tout   = (lat >= TO);
    nwait  = tout ? TO : lat + 1;
    nstall = 0;
    drive(regw, rd, wr, rsrc, addr, wd, rdad);
    bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom();
    #1;
    if (stall_M) nstall++;
    chk("mem_req_idle", bus.dmem_req, 0);
    for (int unsigned k = 0; k < nwait; k++) begin
      step();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom();
      if (!tout && k == lat) begin
        bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
      end
      #1;
      if (stall_M) nstall++;
      chk("mem_req_wait", bus.dmem_req, 1);
      chk("mem_addr", bus.dmem_addr, addr);
      chk("mem_we", bus.dmem_we, wr);
      chk("mem_wdata", bus.dmem_wdata, wd);
      chk("mem_bubble", RegW_enable_W, 0);
    end
    step();
    bus.dmem_ack = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom();
    #1;
    chk("mem_req_done", bus.dmem_req, 0);
    chk("mem_stall_done", stall_M, 0);
    step();
    bus.dmem_ack = 1'b0;
    chk("mem_stall_cnt", nstall, nwait + 1);
    chk("mem_regw", RegW_enable_W, regw && !tout);
    chk("mem_rsrc", Result_src_W, rsrc);
    chk("mem_res", ALU_result_W, addr);
    chk("mem_rdata", Read_Data_W, tout ? 32'h0 : rdata);
    chk("mem_rd", RDadd_W, rdad);
    chk("mem_err", mem_err, tout);
    chk("mem_mis", mem_misalign, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_stall", stall_M, 0);
    chk("rst_regw", RegW_enable_W, 0);
    chk("rst_alu", ALU_result_W, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_mis", mem_misalign, 0);

    do_alu(1'b1, 1'b0, 32'h0000_0042, 5'd7);
    do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd3, 2, 32'hCAFE_F00D);
    do_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h1234_5678, 5'd0, 0, 32'h0);
    do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd9, 99, 32'h0);
    do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0308, 32'h0, 5'd10, TO - 1, 32'h5A5A_A5A5);
    do_mem(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 5'd11, 1, 32'h0BAD_0BAD);
    do_misalign(1'b1, 1'b0, 32'h0000_0102);
    do_alu(1'b1, 1'b0, 32'h0000_0043, 5'd8);

    for (int i = 0; i < 300; i++) begin
      int unsigned kind;
      int unsigned rw;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rw   = $urandom_range(0, 2);
      a    = $urandom();
      if (kind < 4) begin
        do_alu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 5'($urandom()));
      end else if (kind < 9) begin
        a[1:0] = 2'b00;
        do_mem(rw != 1, rw != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
               $urandom(), 5'($urandom()), $urandom_range(0, TO + 1), $urandom());
      end else begin
        a[1:0] = 2'($urandom_range(1, 3));
        do_misalign(rw != 1, rw != 0, a);
      end
    end

    // Reset in the middle of WAIT, followed by a late ack that must be ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 5'd12);
    step();
    step();
    chk("rw_req_pre", bus.dmem_req, 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rw_req", bus.dmem_req, 0);
    chk("rw_stall", stall_M, 0);
    chk("rw_regw", RegW_enable_W, 0);
    chk("rw_alu", ALU_result_W, 0);
    chk("rw_rdata", Read_Data_W, 0);
    chk("rw_rd", RDadd_W, 0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFEED_FACE;
    step();
    bus.dmem_ack = 1'b0;
    chk("late_req", bus.dmem_req, 0);
    chk("late_rdata", Read_Data_W, 0);
    chk("late_regw", RegW_enable_W, 0);
    chk("late_err", mem_err, 0);
    do_alu(1'b1, 1'b0, 32'h0000_0077, 5'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
